// File: rtl/pipe_acc.sv
// pipe_acc: windowed accumulator behind the three-stage arithmetic pipeline.
// It sums every W accepted samples and pushes each window sum into a 2-entry
// result FIFO. The FIFO head is presented on a valid/ready output. Upstream
// cannot stall, so a result that finds the FIFO full is dropped and the
// sticky ovf flag is set.
// Optional feature macro: PIPE_ACC_MAX_EN adds a per-window running maximum.
// That maximum is carried with each FIFO entry and presented on out_max.
module pipe_acc #(
    parameter int N     = 10,
    parameter int W     = 8,
    parameter int ACC_W = N + $clog2(W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
`ifdef PIPE_ACC_MAX_EN
    output logic [N-1:0]     out_max,
`endif
    output logic             ovf
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
`ifdef PIPE_ACC_MAX_EN
        logic [N-1:0]     mx;
`endif
    } ent_t;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    ent_t [1:0]       mem_q, mem_d;
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       occ_q, occ_d;
    logic             ovf_q, ovf_d;
`ifdef PIPE_ACC_MAX_EN
    logic [N-1:0]     max_q, max_d;
    logic [N-1:0]     max_nxt;
`endif

    logic             accept, last, push, pop, full, push_ok;
    logic [ACC_W-1:0] sum_nxt;
    ent_t             ent_new;
    ent_t             head;

    // Window accumulation, FIFO push/pop bookkeeping and overflow detection.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        occ_d   = occ_q;
        ovf_d   = ovf_q;
        ent_new = '0;

        accept  = in_valid & ~flush;
        last    = (cnt_q == CNT_LAST);
        sum_nxt = acc_q + ACC_W'(in_data);
        push    = accept & last;
        pop     = (occ_q != 2'd0) & out_ready;
        full    = (occ_q == 2'd2);
        // A push into a full FIFO survives only if the head leaves this cycle.
        push_ok = push & (~full | pop);

        ent_new.sum = sum_nxt;
`ifdef PIPE_ACC_MAX_EN
        max_d   = max_q;
        max_nxt = (in_data > max_q) ? in_data : max_q;
        ent_new.mx = max_nxt;
`endif

        // Flush wins over a sample presented in the same cycle.
        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
`ifdef PIPE_ACC_MAX_EN
            max_d = '0;
`endif
        end else if (accept) begin
            if (last) begin
                acc_d = '0;
                cnt_d = '0;
`ifdef PIPE_ACC_MAX_EN
                max_d = '0;
`endif
            end else begin
                acc_d = sum_nxt;
                cnt_d = cnt_q + 1'b1;
`ifdef PIPE_ACC_MAX_EN
                max_d = max_nxt;
`endif
            end
        end

        // When full, wptr == rptr, so an accepted push overwrites the
        // entry that is being popped on the same edge.
        if (push_ok) begin
            mem_d[wptr_q] = ent_new;
            wptr_d        = ~wptr_q;
        end
        if (pop)
            rptr_d = ~rptr_q;

        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (push & ~push_ok)
            ovf_d = 1'b1;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            mem_q  <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            occ_q  <= 2'd0;
            ovf_q  <= 1'b0;
`ifdef PIPE_ACC_MAX_EN
            max_q  <= '0;
`endif
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
`ifdef PIPE_ACC_MAX_EN
            max_q  <= max_d;
`endif
        end
    end

    // Outputs come straight from flops; the head reads as zero when the FIFO is empty.
    always_comb begin
        head      = mem_q[rptr_q];
        out_valid = (occ_q != 2'd0);
        out_data  = out_valid ? head.sum : '0;
`ifdef PIPE_ACC_MAX_EN
        out_max   = out_valid ? head.mx : '0;
`endif
        ovf       = ovf_q;
    end

endmodule

// File: doc/pipe_acc.md
# pipe_acc

Windowed accumulator that sits directly downstream of the three-stage arithmetic pipeline. It consumes that pipeline's N-bit result stream `F` with a qualifying valid, sums every W valid samples, and presents each window sum on a valid/ready output. A 2-entry result FIFO absorbs short consumer stalls. The upstream pipeline cannot stall, so there is no input ready and overflow is flagged rather than back-pressured.

## Interface
- `N`, default 10: input sample width; matches the upstream pipeline width.
- `W`, default 8: samples per window; legal range is W ≥ 2, and W need not be a power of two.
- `ACC_W`, default N+$clog2(W): accumulator and result width; sized so a window sum can never wrap.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `in_valid`  in  1: `in_data` holds a sample this cycle.
- `in_data`  in  N: sample, unsigned; this is the upstream `F`.
- `flush`  in  1: abandon the partial window.
- `out_valid`  out  1: FIFO is non-empty.
- `out_ready`  in  1: consumer accepts the head entry this cycle.
- `out_data`  out  ACC_W: FIFO head entry; 0 when the FIFO is empty.
- `ovf`  out  1: sticky flag; a window result was dropped.
- `out_max`  out  N: maximum sample of the head entry's window. Present only with `PIPE_ACC_MAX_EN`.

## Operation
- Inputs are unsigned. The upstream block wraps modulo 2^N, so no sign handling is performed here.
- Window counter `cnt`, range 0..W-1, counts accepted samples only. Gaps in `in_valid` do not advance it.
- A sample is accepted when `in_valid=1` and `flush=0`. On acceptance:
  - If `cnt < W-1`: `acc <= acc + in_data` and `cnt <= cnt+1`.
  - If `cnt == W-1`: `acc + in_data` is pushed to the FIFO, and `acc` and `cnt` both reset to 0 on the same edge.
- `flush=1`: `acc` and `cnt` clear to 0, and any sample presented that cycle is discarded. Flush has priority over `in_valid`. The FIFO and `ovf` are unaffected.
- FIFO depth is 2, implemented as a circular buffer with read/write pointers and an occupancy count.
  - Pop occurs when `out_valid & out_ready`.
  - Push occurs on window completion.
- Push while full:
  - With a pop in the same cycle: the push is accepted and occupancy stays at 2.
  - With no pop: the new result is dropped, `ovf` is set, and the FIFO contents are unchanged.
- `ovf` clears only on reset.
- Push into an empty FIFO with `out_ready=1` in the same cycle is not a bypass. The entry becomes visible the next cycle.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `ovf=0`, `out_max=0`. Internally, `acc=0`, `cnt=0`, FIFO empty.
- Reset takes effect immediately on `rst_n` falling, including mid-window and mid-handshake.
- Latency: the result is on `out_data` with `out_valid=1` in the cycle after the edge that accepts the W-th sample.
- `out_valid`/`out_data` are registered and change only on clock edges. An entry stays stable until popped.
- Throughput: one sample per cycle. With `out_ready` tied high the FIFO never holds more than 1 entry.

## Configuration
- `PIPE_ACC_MAX_EN` defined:
  - A running maximum register tracks the largest accepted sample in the current window.
  - The maximum is stored alongside each FIFO entry and presented on `out_max`.
  - The running maximum clears with `acc`, on flush, and on reset.
- `PIPE_ACC_MAX_EN` undefined:
  - The `out_max` port, the maximum register, and the FIFO max field are not compiled.
  - All other behaviour is identical.

## Test plan
- W=4, `out_ready=1`, samples 1, 2, 3, 4 on consecutive cycles → `out_data=10` with `out_valid=1` for exactly one cycle, in the cycle after the 4th sample; `ovf=0`.
- W=4, samples 1, 2, 3, 4 with 2 idle cycles between each → `out_data=10` one cycle after the last sample; idle cycles do not advance `cnt`.
- W=4, `out_ready=0`, three full windows of 1023 → two entries of 4092 held, third window dropped, `ovf=1`. Then `out_ready=1` → 4092 is popped twice, then `out_valid=0`; `ovf` remains 1.
- W=4, samples 9, 9, then `flush` asserted together with a sample of 100, then 5, 5, 5, 5 → a single result of 20.
- `rst_n` pulsed low after 2 samples of a window, with one FIFO entry pending → all outputs 0 immediately. After release, 1, 1, 1, 1 → 4.
- With `PIPE_ACC_MAX_EN`, W=4, samples 7, 300, 2, 9 → `out_data=318`, `out_max=300`. The next window 1, 1, 1, 1 → `out_max=1`.
